// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver, 1 start / DATA_BITS data (LSB first) / 1 stop, no parity
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clock,
    input  logic                 nreset,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] MID_START = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] MID_BIT   = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] LAST_BIT  = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t               state_q, state_d;
    logic                 sync1_q, rxs_q;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= rx;
            rxs_q   <= sync1_q;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Every decision is taken on a tick; between ticks everything holds.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        if (tick) begin
            cnt_d = cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (!rxs_q) state_d = START;
                end
                START: begin
                    if (cnt_q == MID_START) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = rxs_q ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt_q == MID_BIT) begin
                        cnt_d   = '0;
                        shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
                        idx_d   = idx_q + 1'b1;
                        if (idx_q == LAST_BIT) state_d = STOP;
                    end
                end
                STOP: begin
                    if (cnt_q == MID_BIT) begin
                        cnt_d = '0;
                        if (rxs_q) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = BREAK;
                        end
                    end
                end
                BREAK: begin
                    // Hold here until the line returns high so a break reports once.
                    cnt_d = '0;
                    if (rxs_q) state_d = IDLE;
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx against a frame-level reference queue
module tb_uart_rx;

    logic       clock = 1'b0;
    logic       nreset = 1'b0;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clock    (clock),
        .nreset   (nreset),
        .tick     (tick),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;
    int tdiv = 1;
    int tcnt = 0;
    int cyc = 0;

    always @(negedge clock) begin
        tick = (tcnt == 0);
        tcnt = (tcnt + 1) % tdiv;
    end

    always @(posedge clock) cyc <= cyc + 1;

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int n_err = 0, busy_bad = 0, overlap = 0, dbl = 0, stray = 0;
    int busy_run = 0, busy_max = 0, valid_cyc = 0;
    logic prev_busy = 1'b0, prev_valid = 1'b0, prev_ferr = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(negedge clock) begin
        if (nreset) begin
            if (rx_valid) begin
                got_q.push_back(rx_data);
                valid_cyc = cyc;
                if (busy !== 1'b0 || prev_busy !== 1'b1) busy_bad++;
            end
            if (frame_err) n_err++;
            if (rx_valid && frame_err) overlap++;
            if ((rx_valid && prev_valid) || (frame_err && prev_ferr)) dbl++;
            if (!rx_valid && rx_data !== prev_data) stray++;
            busy_run = busy ? busy_run + 1 : 0;
            if (busy_run > busy_max) busy_max = busy_run;
        end
        prev_busy  = busy;
        prev_valid = rx_valid;
        prev_ferr  = frame_err;
        prev_data  = rx_data;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // p100 is the bit period in hundredths of a clock, so baud offsets can be fractional.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int p100,
                              output int start_cyc);
        logic [9:0] bits;
        int n;
        n = 0;
        bits = {stop_ok, d, 1'b0};
        start_cyc = cyc;
        for (int k = 0; k < 10; k++) begin
            rx = bits[k];
            while (n < ((k + 1) * p100) / 100) begin
                @(negedge clock);
                n++;
            end
        end
        if (stop_ok) exp_q.push_back(d);
    endtask

    task automatic check_frames(input string tag);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            chk({tag, "_data"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic set_div(input int d);
        tdiv = d;
        tcnt = 0;
    endtask

    initial begin
        #50_000_000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        logic [7:0] d;

        idle(3);
        #1;
        chk("reset_rx_data", 32'(rx_data), 32'h00);
        chk("reset_rx_valid", 32'(rx_valid), 32'h0);
        chk("reset_frame_err", 32'(frame_err), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        nreset = 1'b1;
        idle(20);

        // single frame, tick every clock
        set_div(1);
        n_err = 0;
        send_frame(8'hA5, 1'b1, 1600, sc);
        idle(16);
        chk("single_latency", 32'(valid_cyc - sc), 32'd155);
        chk("single_ferr", 32'(n_err), 32'd0);
        chk("single_busy_edge", 32'(busy_bad), 32'd0);
        check_frames("single");

        // back-to-back frames, tick every 4th clock
        set_div(4);
        send_frame(8'h00, 1'b1, 6400, sc);
        send_frame(8'hFF, 1'b1, 6400, sc);
        send_frame(8'h3C, 1'b1, 6400, sc);
        idle(128);
        chk("b2b_ferr", 32'(n_err), 32'd0);
        check_frames("b2b");

        // start glitch
        set_div(1);
        busy_max = 0;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(40);
        chk("glitch_busy_window", 32'(busy_max >= 1 && busy_max <= 8), 32'd1);
        chk("glitch_ferr", 32'(n_err), 32'd0);
        check_frames("glitch");

        // framing error followed by a long break
        send_frame(8'h55, 1'b0, 1600, sc);
        idle(40 * 16);
        rx = 1'b1;
        idle(32);
        chk("ferr_count", 32'(n_err), 32'd1);
        chk("ferr_data_held", 32'(rx_data), 32'h3C);
        chk("ferr_no_stray", 32'(stray), 32'd0);
        check_frames("ferr_none");
        send_frame(8'h81, 1'b1, 1600, sc);
        idle(16);
        chk("ferr_after_count", 32'(n_err), 32'd1);
        check_frames("after_break");

        // reset in the middle of data bit 4 of 0x96
        d = 8'h96;
        rx = 1'b0;
        idle(16);
        for (int k = 0; k < 4; k++) begin
            rx = d[k];
            idle(16);
        end
        rx = d[4];
        idle(8);
        nreset = 1'b0;
        #1;
        chk("mrst_rx_data", 32'(rx_data), 32'h00);
        chk("mrst_rx_valid", 32'(rx_valid), 32'h0);
        chk("mrst_frame_err", 32'(frame_err), 32'h0);
        chk("mrst_busy", 32'(busy), 32'h0);
        rx = 1'b1;
        idle(3);
        nreset = 1'b1;
        idle(32);
        check_frames("mrst_none");
        send_frame(8'h96, 1'b1, 1600, sc);
        idle(16);
        chk("mrst_ferr", 32'(n_err), 32'd1);
        check_frames("mrst_after");

        // baud tolerance +4% / -4%
        set_div(4);
        send_frame(8'hC3, 1'b1, 6656, sc);
        idle(128);
        send_frame(8'hC3, 1'b1, 6144, sc);
        idle(128);
        chk("tol_ferr", 32'(n_err), 32'd1);
        check_frames("tol");

        // randomized frames and tick rates
        for (int i = 0; i < 8; i++) begin
            d = 8'($urandom);
            set_div(int'($urandom_range(1, 4)));
            send_frame(d, 1'b1, 1600 * tdiv, sc);
            idle(int'($urandom_range(0, 20)));
        end
        idle(64);
        chk("rand_ferr", 32'(n_err), 32'd1);
        check_frames("rand");

        chk("no_overlap", 32'(overlap), 32'd0);
        chk("single_cycle_pulses", 32'(dbl), 32'd0);
        chk("busy_falls_with_valid", 32'(busy_bad), 32'd0);
        chk("data_only_on_valid", 32'(stray), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
